universal_shift_reg: RTL and testbench

Parametrised universal shift register with WIDTH-bit stages and DEPTH stages. Supports hold, shift left, shift right and rotate modes, parallel load, a selectable tap output, and an autonomous burst engine that performs a programmed number of shift steps. It is the general-purpose successor to the fixed 8-stage serial shift register in the qlf_k4n8 test designs. It is intended to exercise FF chains, wide muxing and small FSMs in fabric.

---
 rtl/universal_shift_reg_if.sv | 30 +++
 rtl/universal_shift_reg.sv | 116 +++++++++++
 tb/tb_universal_shift_reg.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/universal_shift_reg_if.sv
// rtl/universal_shift_reg_if.sv - control/data bundle for the universal shift register
interface universal_shift_reg_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       shift_in;
  logic                   load;
  logic [WIDTH*DEPTH-1:0] load_data;
  logic [CNT_W-1:0]       tap_sel;
  logic                   burst_start;
  logic [CNT_W-1:0]       burst_len;
  logic [WIDTH*DEPTH-1:0] par_out;
  logic [WIDTH-1:0]       shift_out;
  logic [WIDTH-1:0]       tap_out;
  logic                   busy;
  logic                   done;

  modport master (
    output en, mode, shift_in, load, load_data, tap_sel, burst_start, burst_len,
    input  par_out, shift_out, tap_out, busy, done
  );

  modport slave (
    input  en, mode, shift_in, load, load_data, tap_sel, burst_start, burst_len,
    output par_out, shift_out, tap_out, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - multi-lane universal shift register with tap and burst engine
module universal_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic                  clk,
  input logic                  clr,
  universal_shift_reg_if.slave bus
);

  typedef logic [DEPTH-1:0][WIDTH-1:0] stage_t;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  stage_t           stage_q, stage_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       bmode_q, bmode_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] len_sat;
  logic [1:0]       eff_mode;
  logic [WIDTH-1:0] tap_val;

  // One step of the selected mode applied to every stage at once.
  function automatic stage_t step_fn(input stage_t s, input logic [1:0] m,
                                     input logic [WIDTH-1:0] sin);
    stage_t r;
    r = s;
    case (m)
      2'b01: begin
        r[0] = sin;
        for (int i = 1; i < DEPTH; i++) r[i] = s[i-1];
      end
      2'b10: begin
        r[DEPTH-1] = sin;
        for (int i = 0; i < DEPTH - 1; i++) r[i] = s[i+1];
      end
      2'b11: begin
        r[0] = s[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) r[i] = s[i-1];
      end
      default: r = s;
    endcase
    return r;
  endfunction

  // Oversized burst lengths clamp to one full pass through the chain.
  assign len_sat = (bus.burst_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.burst_len;

  // Next-state: load wins, then an active burst, then burst_start, then a single step.
  always_comb begin
    stage_d = stage_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bmode_d = bmode_q;
    done_d  = 1'b0;
    if (bus.load) begin
      stage_d = bus.load_data;
      if (state_q == BURST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (state_q == BURST) begin
      stage_d = step_fn(stage_q, bmode_q, bus.shift_in);
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q <= CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
    end else if (bus.burst_start) begin
      if (len_sat != '0) begin
        cnt_d   = len_sat;
        bmode_d = bus.mode;
        state_d = BURST;
      end else begin
        done_d = 1'b1;
      end
    end else if (bus.en) begin
      stage_d = step_fn(stage_q, bus.mode, bus.shift_in);
    end
  end

  // State register; clr abandons any burst without a done pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stage_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bmode_q <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
      done_q  <= done_d;
    end
  end

  // Tap mux; out-of-range selects fall back to the last stage.
  always_comb begin
    tap_val = stage_q[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.tap_sel == CNT_W'(i)) tap_val = stage_q[i];
    end
  end

  assign eff_mode      = (state_q == BURST) ? bmode_q : bus.mode;
  assign bus.par_out   = stage_q;
  assign bus.shift_out = (eff_mode == 2'b10) ? stage_q[0] : stage_q[DEPTH-1];
  assign bus.tap_out   = tap_val;
  assign bus.busy      = (state_q == BURST);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed-vector bench for universal_shift_reg
module tb_universal_shift_reg;
  logic clk;
  logic clr;
  int   vec_count;
  int   err_count;

  universal_shift_reg_if #(.WIDTH(1), .DEPTH(8)) bus ();

  universal_shift_reg #(.WIDTH(1), .DEPTH(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [7:0] v);
    bus.load      = 1'b1;
    bus.load_data = v;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    vec_count++;
    if (bus.par_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_count++;
      $display("FAIL reset_init par_out=%h busy=%b done=%b expected 00/0/0", bus.par_out, bus.busy, bus.done);
    end
    load_value(8'hFF);
    bus.load = 1'b1;
    vec_count++;
    if (bus.par_out !== 8'hFF) begin
      err_count++;
      $display("FAIL reset_preload par_out=%h expected=ff", bus.par_out);
    end
    #2 clr = 1'b1;
    #1;
    vec_count++;
    if (bus.par_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_count++;
      $display("FAIL reset_async par_out=%h busy=%b done=%b expected 00/0/0", bus.par_out, bus.busy, bus.done);
    end
    bus.load = 1'b0;
    #1 clr = 1'b0;
  endtask

  task automatic test_shift_left();
    logic pat [8];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.mode = 2'b01;
    bus.en   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.shift_in = pat[k];
      tick();
    end
    bus.en = 1'b0;
    vec_count++;
    if (bus.par_out !== 8'b10110010) begin
      err_count++;
      $display("FAIL shl_pattern par_out=%b expected=10110010", bus.par_out);
    end
    vec_count++;
    if (bus.shift_out !== 1'b1) begin
      err_count++;
      $display("FAIL shl_shift_out got=%b expected=1", bus.shift_out);
    end
    bus.mode = 2'b00;
    bus.en   = 1'b1;
    tick();
    bus.en = 1'b0;
    vec_count++;
    if (bus.par_out !== 8'b10110010) begin
      err_count++;
      $display("FAIL hold par_out=%b expected=10110010", bus.par_out);
    end
  endtask

  task automatic test_rotate_right();
    load_value(8'h81);
    bus.mode = 2'b11;
    bus.en   = 1'b1;
    tick();
    bus.en = 1'b0;
    vec_count++;
    if (bus.par_out !== 8'h03) begin
      err_count++;
      $display("FAIL rotate par_out=%h expected=03", bus.par_out);
    end
    bus.mode     = 2'b10;
    bus.shift_in = 1'b0;
    bus.en       = 1'b1;
    tick();
    bus.en = 1'b0;
    vec_count++;
    if (bus.par_out !== 8'h01) begin
      err_count++;
      $display("FAIL shr par_out=%h expected=01", bus.par_out);
    end
    vec_count++;
    if (bus.shift_out !== 1'b1) begin
      err_count++;
      $display("FAIL shr_shift_out got=%b expected=1", bus.shift_out);
    end
    bus.tap_sel = 4'd0;
    #1;
    vec_count++;
    if (bus.tap_out !== 1'b1) begin
      err_count++;
      $display("FAIL tap0 got=%b expected=1", bus.tap_out);
    end
    bus.tap_sel = 4'd9;
    #1;
    vec_count++;
    if (bus.tap_out !== 1'b0) begin
      err_count++;
      $display("FAIL tap9 got=%b expected=0", bus.tap_out);
    end
    load_value(8'h80);
    bus.tap_sel = 4'd12;
    #1;
    vec_count++;
    if (bus.tap_out !== 1'b1) begin
      err_count++;
      $display("FAIL tap12 got=%b expected=1", bus.tap_out);
    end
    bus.tap_sel = 4'd0;
  endtask

  task automatic test_burst();
    logic [7:0] e;
    load_value(8'h01);
    bus.mode        = 2'b01;
    bus.shift_in    = 1'b0;
    bus.burst_len   = 4'd3;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    bus.mode        = 2'b10;
    vec_count++;
    if (bus.busy !== 1'b1 || bus.par_out !== 8'h01) begin
      err_count++;
      $display("FAIL burst_start busy=%b par_out=%h expected 1/01", bus.busy, bus.par_out);
    end
    vec_count++;
    if (bus.shift_out !== 1'b0) begin
      err_count++;
      $display("FAIL burst_eff_mode shift_out=%b expected=0", bus.shift_out);
    end
    for (int s = 1; s <= 3; s++) begin
      bus.en = s[0];
      tick();
      e = 8'h01 << s;
      vec_count++;
      if (bus.par_out !== e || bus.busy !== (s < 3) || bus.done !== (s == 3)) begin
        err_count++;
        $display("FAIL burst_step%0d par_out=%h busy=%b done=%b expected %h/%b/%b",
                 s, bus.par_out, bus.busy, bus.done, e, (s < 3), (s == 3));
      end
    end
    bus.en   = 1'b0;
    bus.mode = 2'b01;
    tick();
    vec_count++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.par_out !== 8'h08) begin
      err_count++;
      $display("FAIL burst_after done=%b busy=%b par_out=%h expected 0/0/08", bus.done, bus.busy, bus.par_out);
    end
  endtask

  task automatic test_back_to_back();
    load_value(8'h01);
    bus.mode        = 2'b01;
    bus.shift_in    = 1'b0;
    bus.burst_len   = 4'd2;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    tick();
    tick();
    vec_count++;
    if (bus.done !== 1'b1 || bus.par_out !== 8'h04) begin
      err_count++;
      $display("FAIL b2b_first done=%b par_out=%h expected 1/04", bus.done, bus.par_out);
    end
    bus.burst_start = 1'b1;
    bus.burst_len   = 4'd1;
    bus.mode        = 2'b11;
    tick();
    bus.burst_start = 1'b0;
    vec_count++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.par_out !== 8'h04) begin
      err_count++;
      $display("FAIL b2b_accept busy=%b done=%b par_out=%h expected 1/0/04", bus.busy, bus.done, bus.par_out);
    end
    tick();
    vec_count++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.par_out !== 8'h08) begin
      err_count++;
      $display("FAIL b2b_second busy=%b done=%b par_out=%h expected 0/1/08", bus.busy, bus.done, bus.par_out);
    end
    tick();
  endtask

  task automatic test_edge_bursts();
    logic [7:0] e;
    load_value(8'h5A);
    bus.burst_len   = 4'd0;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    vec_count++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.par_out !== 8'h5A) begin
      err_count++;
      $display("FAIL len0 done=%b busy=%b par_out=%h expected 1/0/5a", bus.done, bus.busy, bus.par_out);
    end
    tick();
    vec_count++;
    if (bus.done !== 1'b0 || bus.par_out !== 8'h5A) begin
      err_count++;
      $display("FAIL len0_after done=%b par_out=%h expected 0/5a", bus.done, bus.par_out);
    end
    load_value(8'h01);
    bus.mode        = 2'b11;
    bus.burst_len   = 4'd15;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k == 8) ? 8'h01 : (8'h01 << k);
      vec_count++;
      if (bus.par_out !== e || bus.busy !== (k < 8) || bus.done !== (k == 8)) begin
        err_count++;
        $display("FAIL len15_step%0d par_out=%h busy=%b done=%b expected %h/%b/%b",
                 k, bus.par_out, bus.busy, bus.done, e, (k < 8), (k == 8));
      end
    end
    tick();
    load_value(8'h01);
    bus.mode        = 2'b01;
    bus.shift_in    = 1'b0;
    bus.burst_len   = 4'd5;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    tick();
    vec_count++;
    if (bus.par_out !== 8'h02 || bus.busy !== 1'b1) begin
      err_count++;
      $display("FAIL abort_step1 par_out=%h busy=%b expected 02/1", bus.par_out, bus.busy);
    end
    load_value(8'hC3);
    vec_count++;
    if (bus.par_out !== 8'hC3 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_count++;
      $display("FAIL abort_load par_out=%h busy=%b done=%b expected c3/0/0", bus.par_out, bus.busy, bus.done);
    end
    tick();
    vec_count++;
    if (bus.par_out !== 8'hC3 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_count++;
      $display("FAIL abort_after par_out=%h busy=%b done=%b expected c3/0/0", bus.par_out, bus.busy, bus.done);
    end
  endtask

  task automatic test_clr_mid_burst();
    logic [7:0] e;
    load_value(8'h01);
    bus.mode        = 2'b01;
    bus.shift_in    = 1'b0;
    bus.burst_len   = 4'd6;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    tick();
    tick();
    #2 clr = 1'b1;
    #1;
    vec_count++;
    if (bus.par_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_count++;
      $display("FAIL clr_mid par_out=%h busy=%b done=%b expected 00/0/0", bus.par_out, bus.busy, bus.done);
    end
    #1 clr = 1'b0;
    tick();
    vec_count++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      err_count++;
      $display("FAIL clr_no_done done=%b busy=%b expected 0/0", bus.done, bus.busy);
    end
    load_value(8'h01);
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = 8'h01 << k;
      vec_count++;
      if (bus.par_out !== e || bus.busy !== (k < 6) || bus.done !== (k == 6)) begin
        err_count++;
        $display("FAIL rerun_step%0d par_out=%h busy=%b done=%b expected %h/%b/%b",
                 k, bus.par_out, bus.busy, bus.done, e, (k < 6), (k == 6));
      end
    end
  endtask

  initial begin
    vec_count       = 0;
    err_count       = 0;
    clr             = 1'b1;
    bus.en          = 1'b0;
    bus.mode        = 2'b00;
    bus.shift_in    = 1'b0;
    bus.load        = 1'b0;
    bus.load_data   = '0;
    bus.tap_sel     = '0;
    bus.burst_start = 1'b0;
    bus.burst_len   = '0;
    tick();
    tick();
    clr = 1'b0;
    test_reset();
    test_shift_left();
    test_rotate_right();
    test_burst();
    test_back_to_back();
    test_edge_bursts();
    test_clr_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
